// File: rtl/divider.sv
// rtl/divider.sv - 16-bit restoring divider, one quotient bit per clock; DIVIDER_SIGNED_EN enables signed mode
module divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] destination,
    input  logic [15:0] source,
    input  logic [15:0] flags,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [3:0]  count;
    logic [15:0] work;
    logic [15:0] divisor;
    logic [15:0] part;

    logic        accept;
    logic [16:0] shifted;
    logic [17:0] trial;
    logic        borrow;
    logic [15:0] part_next;
    logic [15:0] quo_next;
    logic [15:0] quo_final;
    logic [15:0] rem_final;
    logic [15:0] dend_mag;
    logic [15:0] dsor_mag;
    logic        unused_flags;

    assign accept = (state == IDLE) && start;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // work holds the unconsumed dividend bits on the left and the quotient bits built so far on the right
    always_comb begin
        shifted   = {part, work[15]};
        trial     = {1'b0, shifted} - {2'b00, divisor};
        borrow    = trial[17];
        part_next = borrow ? shifted[15:0] : trial[15:0];
        quo_next  = {work[14:0], ~borrow};
    end

`ifdef DIVIDER_SIGNED_EN
    logic signed_mode;
    logic neg_quo;
    logic neg_rem;

    assign signed_mode  = flags[8];
    assign unused_flags = ^{flags[15:9], flags[7:0]};

    always_comb begin
        dend_mag  = (signed_mode && destination[15]) ? (~destination + 16'd1) : destination;
        dsor_mag  = (signed_mode && source[15]) ? (~source + 16'd1) : source;
        quo_final = neg_quo ? (~quo_next + 16'd1) : quo_next;
        rem_final = neg_rem ? (~part_next + 16'd1) : part_next;
    end

    // 0x8000 / 0xFFFF needs no special datapath: magnitude 0x8000 / 1 with a positive sign gives 0x8000
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            neg_rem  <= signed_mode & destination[15];
            neg_quo  <= signed_mode & (destination[15] ^ source[15]);
            overflow <= signed_mode && (destination == 16'h8000) && (source == 16'hFFFF);
        end
    end
`else
    assign unused_flags = ^flags;
    assign overflow     = 1'b0;

    always_comb begin
        dend_mag  = destination;
        dsor_mag  = source;
        quo_final = quo_next;
        rem_final = part_next;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            work      <= 16'd0;
            divisor   <= 16'd0;
            part      <= 16'd0;
            quotient  <= 16'd0;
            remainder <= 16'd0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work    <= dend_mag;
                        divisor <= dsor_mag;
                        part    <= 16'd0;
                        count   <= 4'd0;
                        if (source == 16'd0) begin
                            state     <= DONE;
                            quotient  <= 16'hFFFF;
                            remainder <= destination;
                            div_zero  <= 1'b1;
                        end else begin
                            state    <= RUN;
                            div_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    work  <= quo_next;
                    part  <= part_next;
                    count <= count + 4'd1;
                    if (count == 4'd15) begin
                        quotient  <= quo_final;
                        remainder <= rem_final;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - vector table, handshake/reset sequences and random ops against an arithmetic model
module tb_divider;

`ifdef DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] destination = 16'd0;
    logic [15:0] source = 16'd0;
    logic [15:0] flags = 16'd0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        overflow;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [15:0] d;
        logic [15:0] s;
        logic [15:0] f;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t tbl[11];

    divider dut (
        .clock(clock), .reset(reset), .start(start),
        .destination(destination), .source(source), .flags(flags),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_zero(div_zero), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] d, input logic [15:0] s, input logic sflag,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
        int sd;
        int ss;
        sd = int'($signed(d));
        ss = int'($signed(s));
        dz = (s == 16'd0);
        ov = 1'b0;
        if (s == 16'd0) begin
            q = 16'hFFFF;
            r = d;
        end else if (!(sflag && SIGNED_EN)) begin
            q = d / s;
            r = d % s;
        end else if (sd == -32768 && ss == -1) begin
            q  = 16'h8000;
            r  = 16'h0000;
            ov = 1'b1;
        end else begin
            q = 16'(sd / ss);
            r = 16'(sd % ss);
        end
    endfunction

    task automatic run_and_check(input string name, input logic [15:0] d, input logic [15:0] s,
                                 input logic [15:0] f, input logic [15:0] eq, input logic [15:0] er,
                                 input logic edz, input logic eov);
        int lat;
        int busy_err;
        logic [15:0] q_seen;
        @(negedge clock);
        destination = d;
        source      = s;
        flags       = f;
        start       = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat      = -1;
        busy_err = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (done) begin
                if (busy) busy_err++;
                lat = n;
                break;
            end
            if (!busy) busy_err++;
        end
        q_seen = quotient;
        check({name, " quotient"}, 32'(quotient), 32'(eq));
        check({name, " remainder"}, 32'(remainder), 32'(er));
        check({name, " div_zero"}, 32'(div_zero), 32'(edz));
        check({name, " overflow"}, 32'(overflow), 32'(eov));
        check({name, " latency"}, 32'(lat), edz ? 32'd0 : 32'd16);
        check({name, " busy_shape"}, 32'(busy_err), 32'd0);
        @(negedge clock);
        check({name, " done_pulse"}, 32'({busy, done}), 32'd0);
        check({name, " hold"}, 32'(quotient), 32'(q_seen));
    endtask

    initial begin
        logic [15:0] eq;
        logic [15:0] er;
        logic [15:0] d;
        logic [15:0] s;
        logic [15:0] f;
        logic        edz;
        logic        eov;
        int          lat;

        tbl[0]  = '{16'd100,   16'd7,     16'h0000, 16'd14,     16'd2,     1'b0, 1'b0};
        tbl[1]  = '{16'h1234,  16'h0000,  16'h0000, 16'hFFFF,   16'h1234,  1'b1, 1'b0};
        tbl[2]  = '{16'hFFF9,  16'd2,     16'h0100, SIGNED_EN ? 16'hFFFD : 16'h7FFC,
                    SIGNED_EN ? 16'hFFFF : 16'h0001, 1'b0, 1'b0};
        tbl[3]  = '{16'h8000,  16'hFFFF,  16'h0100, SIGNED_EN ? 16'h8000 : 16'h0000,
                    SIGNED_EN ? 16'h0000 : 16'h8000, 1'b0, SIGNED_EN};
        tbl[4]  = '{16'd1000,  16'd10,    16'h0000, 16'd100,    16'd0,     1'b0, 1'b0};
        tbl[5]  = '{16'hFFFF,  16'd1,     16'h0000, 16'hFFFF,   16'd0,     1'b0, 1'b0};
        tbl[6]  = '{16'd5,     16'd9,     16'h0000, 16'd0,      16'd5,     1'b0, 1'b0};
        tbl[7]  = '{16'hFFFF,  16'hFFFF,  16'h0000, 16'd1,      16'd0,     1'b0, 1'b0};
        tbl[8]  = '{16'hFFF9,  16'hFFFE,  16'h0100, SIGNED_EN ? 16'h0003 : 16'h0000,
                    SIGNED_EN ? 16'hFFFF : 16'hFFF9, 1'b0, 1'b0};
        tbl[9]  = '{16'h0007,  16'hFFFE,  16'h0100, SIGNED_EN ? 16'hFFFD : 16'h0000,
                    16'h0007 ^ (SIGNED_EN ? 16'h0006 : 16'h0000), 1'b0, 1'b0};
        tbl[10] = '{16'hFFF9,  16'h0000,  16'h0100, 16'hFFFF,   16'hFFF9,  1'b1, 1'b0};

        repeat (3) @(negedge clock);
        check("reset outputs", 32'({quotient, remainder}), 32'd0);
        check("reset flags", 32'({busy, done, div_zero, overflow}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_and_check($sformatf("tbl%0d", i), tbl[i].d, tbl[i].s, tbl[i].f,
                          tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov);

        // start pulses mid-run with different operands must be ignored
        @(negedge clock);
        destination = 16'd100;
        source      = 16'd7;
        flags       = 16'h0000;
        start       = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (done) begin
                lat = n;
                break;
            end
            if (n == 4 || n == 15) begin
                destination = 16'h5555;
                source      = 16'h0000;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("hs latency", 32'(lat), 32'd16);
        check("hs quotient", 32'(quotient), 32'd14);
        check("hs remainder", 32'(remainder), 32'd2);
        check("hs div_zero", 32'(div_zero), 32'd0);
        run_and_check("hs next", 16'd200, 16'd3, 16'h0000, 16'd66, 16'd2, 1'b0, 1'b0);

        // reset in the middle of a run
        run_and_check("pre dz", 16'h4321, 16'h0000, 16'h0000, 16'hFFFF, 16'h4321, 1'b1, 1'b0);
        @(negedge clock);
        destination = 16'hFFFF;
        source      = 16'd3;
        start       = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (8) @(negedge clock);
        check("mid busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst outputs", 32'({quotient, remainder}), 32'd0);
        check("rst flags", 32'({busy, done, div_zero, overflow}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst idle", 32'({busy, done}), 32'd0);
        run_and_check("post rst", 16'd1000, 16'd10, 16'h0000, 16'd100, 16'd0, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            d = 16'($urandom);
            f = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       s = 16'd0;
                1:       s = 16'($urandom_range(1, 15));
                2: begin d = 16'h8000; s = 16'hFFFF; end
                3:       s = 16'hFFFF - 16'($urandom_range(0, 3));
                default: s = 16'($urandom);
            endcase
            model(d, s, f[8], eq, er, edz, eov);
            run_and_check($sformatf("rand%0d", i), d, s, f, eq, er, edz, eov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
